// File: rtl/alu16_pkg.sv
// Shared definitions for the ALU16 command issuer: opcode encoding, issuer
// FSM states and the default finish timeout.
package alu16_pkg;

  localparam logic [3:0] OP_ADD     = 4'b0000;
  localparam logic [3:0] OP_SUB     = 4'b0001;
  localparam logic [3:0] OP_MUL     = 4'b0010;
  localparam logic [3:0] OP_DIV     = 4'b0011;
  localparam logic [3:0] OP_AND     = 4'b0100;
  localparam logic [3:0] OP_OR      = 4'b0101;
  localparam logic [3:0] OP_XOR     = 4'b0110;
  localparam logic [3:0] OP_NOT     = 4'b0111;
  localparam logic [3:0] OP_SHL     = 4'b1000;
  localparam logic [3:0] OP_SHR     = 4'b1001;
  localparam logic [3:0] OP_ROL     = 4'b1010;
  localparam logic [3:0] OP_ROR     = 4'b1011;
  localparam logic [3:0] OP_INC     = 4'b1100;
  localparam logic [3:0] OP_DEC     = 4'b1101;
  localparam logic [3:0] OP_TST     = 4'b1110;
  localparam logic [3:0] OP_ILLEGAL = 4'b1111;

  localparam int DEFAULT_TIMEOUT_CYCLES = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  function automatic logic is_illegal(input logic [3:0] op);
    return (op == OP_ILLEGAL);
  endfunction

endpackage

// File: rtl/alu_cmd_timeout.sv
// Clearable up-counter that stops at TIMEOUT_CYCLES-1 and flags that
// terminal count; times the issuer's wait for the control unit's finish.
module alu_cmd_timeout
  import alu16_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] TC_VAL = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tc = (cnt_q == TC_VAL);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !tc) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/alu_cmd_issuer.sv
// ALU command issuer: request -> start pulse -> wait finish -> response.
// Optional statistics counters are built when ALU_CMD_STATS_EN is defined.
module alu_cmd_issuer
  import alu16_pkg::*;
#(
  parameter int W              = 16,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [3:0]   req_op,
  input  logic [W-1:0] req_a,
  input  logic [W-1:0] req_b,
  output logic [3:0]   cu_s,
  output logic         cu_start,
  input  logic         cu_finish,
  output logic [W-1:0] dp_a,
  output logic [W-1:0] dp_b,
  input  logic [W-1:0] dp_result,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_result,
  output logic [3:0]   rsp_op,
  output logic         rsp_err,
  output logic [15:0]  stat_done,
  output logic [15:0]  stat_err
);

  state_e       state_q, state_d;
  logic         req_ready_q, req_ready_d;
  logic         cu_start_q, cu_start_d;
  logic [3:0]   cu_s_q, cu_s_d;
  logic [W-1:0] dp_a_q, dp_a_d, dp_b_q, dp_b_d;
  logic         rsp_valid_q, rsp_valid_d;
  logic [W-1:0] rsp_result_q, rsp_result_d;
  logic [3:0]   rsp_op_q, rsp_op_d;
  logic         rsp_err_q, rsp_err_d;
  logic         tmo_clr, tmo_en, tmo_tc;

  assign req_ready  = req_ready_q;
  assign cu_start   = cu_start_q;
  assign cu_s       = cu_s_q;
  assign dp_a       = dp_a_q;
  assign dp_b       = dp_b_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_op     = rsp_op_q;
  assign rsp_err    = rsp_err_q;

  // The counter is cleared in START, so WAIT always begins at zero.
  assign tmo_clr = (state_q == ST_START);
  assign tmo_en  = (state_q == ST_WAIT) && !cu_finish;

  alu_cmd_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk (clk),
    .rst (rst),
    .clr (tmo_clr),
    .en  (tmo_en),
    .tc  (tmo_tc)
  );

  always_comb begin
    state_d      = state_q;
    req_ready_d  = req_ready_q;
    cu_start_d   = 1'b0;
    cu_s_d       = cu_s_q;
    dp_a_d       = dp_a_q;
    dp_b_d       = dp_b_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_op_d     = rsp_op_q;
    rsp_err_d    = rsp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          cu_s_d      = req_op;
          dp_a_d      = req_a;
          dp_b_d      = req_b;
          req_ready_d = 1'b0;
          // Illegal opcodes bypass the control unit entirely.
          if (is_illegal(req_op)) begin
            state_d      = ST_RESP;
            rsp_valid_d  = 1'b1;
            rsp_result_d = '0;
            rsp_op_d     = req_op;
            rsp_err_d    = 1'b1;
          end else begin
            state_d    = ST_START;
            cu_start_d = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (cu_finish) begin
          state_d      = ST_RESP;
          rsp_valid_d  = 1'b1;
          rsp_result_d = dp_result;
          rsp_op_d     = cu_s_q;
          rsp_err_d    = 1'b0;
        end else if (tmo_tc) begin
          state_d      = ST_RESP;
          rsp_valid_d  = 1'b1;
          rsp_result_d = '0;
          rsp_op_d     = cu_s_q;
          rsp_err_d    = 1'b1;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        req_ready_d = 1'b1;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      req_ready_q  <= 1'b1;
      cu_start_q   <= 1'b0;
      cu_s_q       <= 4'd0;
      dp_a_q       <= '0;
      dp_b_q       <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_op_q     <= 4'd0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_ready_q  <= req_ready_d;
      cu_start_q   <= cu_start_d;
      cu_s_q       <= cu_s_d;
      dp_a_q       <= dp_a_d;
      dp_b_q       <= dp_b_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_op_q     <= rsp_op_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

`ifdef ALU_CMD_STATS_EN
  logic [15:0] stat_done_q, stat_done_d, stat_err_q, stat_err_d;

  assign stat_done = stat_done_q;
  assign stat_err  = stat_err_q;

  // Count accepted responses by outcome, saturating at all-ones.
  always_comb begin
    stat_done_d = stat_done_q;
    stat_err_d  = stat_err_q;
    if (rsp_valid_q && rsp_ready) begin
      if (rsp_err_q) begin
        if (stat_err_q != 16'hFFFF) begin
          stat_err_d = stat_err_q + 16'd1;
        end else begin
          stat_err_d = stat_err_q;
        end
      end else begin
        if (stat_done_q != 16'hFFFF) begin
          stat_done_d = stat_done_q + 16'd1;
        end else begin
          stat_done_d = stat_done_q;
        end
      end
    end else begin
      stat_done_d = stat_done_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_done_q <= 16'd0;
      stat_err_q  <= 16'd0;
    end else begin
      stat_done_q <= stat_done_d;
      stat_err_q  <= stat_err_d;
    end
  end
`else
  assign stat_done = 16'd0;
  assign stat_err  = 16'd0;
`endif

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Self-checking bench for alu_cmd_issuer: timeline-based reference model,
// a per-cycle compare process and directed transactions with literal checks.
module tb_alu_cmd_issuer;

  localparam int W = 16;
  localparam int T = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [3:0]    req_op = 4'd0;
  logic [W-1:0]  req_a = '0;
  logic [W-1:0]  req_b = '0;
  logic [3:0]    cu_s;
  logic          cu_start;
  logic          cu_finish = 1'b0;
  logic [W-1:0]  dp_a, dp_b;
  logic [W-1:0]  dp_result = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [W-1:0]  rsp_result;
  logic [3:0]    rsp_op;
  logic          rsp_err;
  logic [15:0]   stat_done, stat_err;

  always #5 clk = ~clk;

  alu_cmd_issuer #(.W(W), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .cu_s(cu_s), .cu_start(cu_start), .cu_finish(cu_finish),
    .dp_a(dp_a), .dp_b(dp_b), .dp_result(dp_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_op(rsp_op), .rsp_err(rsp_err),
    .stat_done(stat_done), .stat_err(stat_err)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic bound_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=no-event expected=event t=%0t", name, $time);
  endtask

  // ---------------- reference model (transaction timeline) ----------------
  int          cyc_now = 0, ended_cyc = 0, acc_cyc = -100, resp_cyc = 0;
  int          fin_cyc = -1, plan_delay = -1;
  logic [15:0] plan_res = '0;
  bit          busy = 0, legal = 0, cmp_en = 0;
  logic        e_req_ready, e_cu_start, e_rsp_valid, e_rsp_err, pend_err;
  logic [3:0]  e_cu_s, e_rsp_op, pend_op;
  logic [15:0] e_dp_a, e_dp_b, e_rsp_result, pend_res, e_stat_done, e_stat_err;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      busy = 0; fin_cyc = -1;
      e_req_ready = 1'b1; e_cu_start = 1'b0; e_cu_s = 4'd0;
      e_dp_a = 16'd0; e_dp_b = 16'd0;
      e_rsp_valid = 1'b0; e_rsp_result = 16'd0; e_rsp_op = 4'd0; e_rsp_err = 1'b0;
      e_stat_done = 16'd0; e_stat_err = 16'd0;
    end else begin
      ended_cyc = cyc_now;
      cyc_now++;
      if (!busy && req_valid) begin
        busy = 1; acc_cyc = ended_cyc; legal = (req_op != 4'hF);
        e_cu_s = req_op; e_dp_a = req_a; e_dp_b = req_b; pend_op = req_op;
        if (!legal) begin
          fin_cyc = -1; resp_cyc = ended_cyc + 1; pend_res = 16'd0; pend_err = 1'b1;
        end else begin
          // Start in cycle acc+1, WAIT spans acc+2 .. acc+T+1.
          fin_cyc = (plan_delay < 0) ? -1 : ended_cyc + 1 + plan_delay;
          if (plan_delay >= 1 && plan_delay <= T) begin
            resp_cyc = fin_cyc + 1; pend_res = plan_res; pend_err = 1'b0;
          end else begin
            resp_cyc = ended_cyc + T + 2; pend_res = 16'd0; pend_err = 1'b1;
          end
        end
      end else if (busy && ended_cyc >= resp_cyc && rsp_ready) begin
        busy = 0;
`ifdef ALU_CMD_STATS_EN
        if (pend_err) begin
          if (e_stat_err != 16'hFFFF) e_stat_err++;
        end else begin
          if (e_stat_done != 16'hFFFF) e_stat_done++;
        end
`endif
      end
      e_req_ready = !busy;
      e_cu_start  = busy && legal && (cyc_now == acc_cyc + 1);
      e_rsp_valid = busy && (cyc_now >= resp_cyc);
      if (busy && cyc_now == resp_cyc) begin
        e_rsp_result = pend_res; e_rsp_op = pend_op; e_rsp_err = pend_err;
      end
    end
  end

  // Model control unit: finish pulse with valid data, junk on dp_result otherwise.
  always @(posedge clk) begin
    #1;
    if (fin_cyc >= 0 && cyc_now == fin_cyc) begin
      cu_finish = 1'b1; dp_result = plan_res;
    end else begin
      cu_finish = 1'b0; dp_result = 16'hBAD0 ^ 16'(cyc_now);
    end
  end

  int start_cnt = 0;
  always @(negedge clk) if (cu_start === 1'b1) start_cnt++;

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("req_ready", req_ready, e_req_ready);
      chk("cu_start", cu_start, e_cu_start);
      chk("cu_s", cu_s, e_cu_s);
      chk("dp_a", dp_a, e_dp_a);
      chk("dp_b", dp_b, e_dp_b);
      chk("rsp_valid", rsp_valid, e_rsp_valid);
      chk("rsp_result", rsp_result, e_rsp_result);
      chk("rsp_op", rsp_op, e_rsp_op);
      chk("rsp_err", rsp_err, e_rsp_err);
      chk("stat_done", stat_done, e_stat_done);
      chk("stat_err", stat_err, e_stat_err);
    end
  end

  // ---------------- directed stimulus ----------------
  int          lat;
  logic [15:0] got_res;
  logic [3:0]  got_op;
  logic        got_err;

  task automatic send(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                      input int dly, input logic [15:0] res, input int hold);
    int n;
    plan_delay = dly; plan_res = res;
    req_op = op; req_a = a; req_b = b; req_valid = 1'b1; start_cnt = 0;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!(busy && acc_cyc == cyc_now - 1) && n < 20);
    if (!(busy && acc_cyc == cyc_now - 1)) bound_fail("accept_bound");
    req_valid = 1'b0;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
    if (rsp_valid !== 1'b1) bound_fail("rsp_bound");
    lat = cyc_now - acc_cyc;
    got_res = rsp_result; got_op = rsp_op; got_err = rsp_err;
    for (int i = 0; i < hold; i++) begin
      chk("hold_req_ready", req_ready, 1'b0);
      chk("hold_rsp_valid", rsp_valid, 1'b1);
      chk("hold_rsp_result", rsp_result, got_res);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("req_ready_after_rsp", req_ready, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst = 1'b1;
    cmp_en = 1;
    #1;
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_cu_start", cu_start, 1'b0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk); #1;

    // ADD 3+4, finish 3 cycles after start
    send(4'b0000, 16'h0003, 16'h0004, 3, 16'h0007, 0);
    chk("add_result", got_res, 16'h0007);
    chk("add_err", got_err, 1'b0);
    chk("add_op", got_op, 4'b0000);
    chk("add_starts", start_cnt, 1);
    chk("add_latency", lat, 5);

    // MUL with 5-cycle response backpressure
    send(4'b0010, 16'h0012, 16'h0003, 2, 16'h0036, 5);
    chk("mul_result", got_res, 16'h0036);
    chk("mul_op", got_op, 4'b0010);
    chk("mul_latency", lat, 4);

    // Illegal opcode
    send(4'b1111, 16'hAAAA, 16'h5555, 3, 16'h1111, 1);
    chk("ill_latency", lat, 1);
    chk("ill_err", got_err, 1'b1);
    chk("ill_result", got_res, 16'h0000);
    chk("ill_starts", start_cnt, 0);

    // Timeout, with a late finish landing during RESP
    send(4'b0001, 16'h0009, 16'h0001, T + 2, 16'h0008, 3);
    chk("tmo_latency", lat, 10);
    chk("tmo_err", got_err, 1'b1);
    chk("tmo_result", got_res, 16'h0000);

    // Finish in the START cycle is ignored -> timeout
    send(4'b0100, 16'h00F0, 16'h0F0F, 0, 16'h0000, 0);
    chk("start_fin_err", got_err, 1'b1);
    chk("start_fin_latency", lat, 10);

    // Finish in the last WAIT cycle still wins over the timeout
    send(4'b1110, 16'h1234, 16'h0000, T, 16'h1234, 0);
    chk("last_wait_err", got_err, 1'b0);
    chk("last_wait_result", got_res, 16'h1234);
    chk("last_wait_latency", lat, 10);

    // Reset during WAIT of a DIV
    plan_delay = -1; req_op = 4'b0011; req_a = 16'h0064; req_b = 16'h0005; req_valid = 1'b1;
    @(posedge clk); #1 req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_cu_s", cu_s, 4'd0);
    chk("mid_rst_dp_a", dp_a, 16'd0);
    chk("mid_rst_req_ready", req_ready, 1'b1);
    chk("mid_rst_rsp_valid", rsp_valid, 1'b0);
    @(posedge clk); #2 rst = 1'b0;
    repeat (T + 4) begin
      @(posedge clk); #1;
      chk("no_rsp_after_rst", rsp_valid, 1'b0);
    end
    send(4'b0000, 16'h0100, 16'h0023, 1, 16'h0123, 0);
    chk("post_rst_result", got_res, 16'h0123);
    chk("post_rst_err", got_err, 1'b0);

    // Statistics from a clean reset: 3 good + 1 illegal
    #2 rst = 1'b1;
    @(posedge clk); #2 rst = 1'b0;
    @(posedge clk); #1;
    send(4'b0000, 16'h0001, 16'h0001, 2, 16'h0002, 0);
    send(4'b0001, 16'h0005, 16'h0002, 4, 16'h0003, 1);
    send(4'b1110, 16'h0000, 16'h0000, 1, 16'h0000, 0);
    send(4'b1111, 16'h0000, 16'h0000, 1, 16'h0000, 0);
    @(posedge clk); #1;
`ifdef ALU_CMD_STATS_EN
    chk("stat_done_lit", stat_done, 16'd3);
    chk("stat_err_lit", stat_err, 16'd1);
`else
    chk("stat_done_lit", stat_done, 16'd0);
    chk("stat_err_lit", stat_err, 16'd0);
`endif

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_cmd_issuer.md
# alu_cmd_issuer

Initiator side of the ALU control-unit handshake. It accepts one ALU command at a time from the processor over a valid/ready request channel and presents the operands to the datapath. It then drives the control unit's opcode select and a one-cycle start pulse, waits for the control unit's finish, captures the datapath result and returns it on a valid/ready response channel. It sits between instruction decode and the ALU16 control unit/datapath pair, and adds illegal-opcode rejection and a finish timeout.

## Interface
Parameters:
- W, 16, operand/result width
- TIMEOUT_CYCLES, 64, max cycles in WAIT before abort (≥2)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  command present
- req_ready  out  1  issuer can accept (high only in IDLE)
- req_op  in  4  opcode, same encoding as control unit `s` (0000 ADD … 1110 TST; 1111 illegal)
- req_a, req_b  in  W  operands
- cu_s  out  4  opcode to control unit
- cu_start  out  1  start pulse to control unit
- cu_finish  in  1  finish from control unit
- dp_a, dp_b  out  W  operands to datapath, held for the whole operation
- dp_result  in  W  datapath result, valid in the cycle cu_finish is high
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_result  out  W  captured result (0 on error)
- rsp_op  out  4  opcode of this response
- rsp_err  out  1  1 = illegal opcode or timeout
- stat_done, stat_err  out  16  statistics counters (see Configuration)

## Operation
- FSM states: IDLE, START, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid: latch op/a/b.
  - If op==1111, go to RESP with err=1, result 0, and no cu_start.
  - Otherwise go to START.
- START:
  - cu_start=1 for exactly this cycle.
  - cu_s=latched op.
  - Clear the timeout counter. Go to WAIT.
- WAIT:
  - cu_start=0; cu_s, dp_a, dp_b held stable.
  - On cu_finish=1: capture dp_result, err=0, go to RESP.
  - Otherwise increment the counter. When the counter reaches TIMEOUT_CYCLES-1 without finish: err=1, result 0, go to RESP.
- RESP:
  - rsp_valid=1; rsp_result, rsp_op and rsp_err stable until accepted.
  - On rsp_ready: go to IDLE.
- cu_finish is ignored outside WAIT, including a finish in the START cycle.
- cu_s and dp_a/dp_b keep the last latched values in IDLE and RESP; they change only on request accept.
- Counter width: clog2(TIMEOUT_CYCLES); no wrap because it is cleared in START.

## Timing
- Reset (asynchronous, immediate):
  - state=IDLE, req_ready=1, cu_start=0, cu_s=0, dp_a=dp_b=0.
  - rsp_valid=0, rsp_result=0, rsp_op=0, rsp_err=0, stats=0.
- Accept at edge N. cu_start is high in cycle N+1. WAIT begins at N+2.
- cu_finish high in cycle M (M ≥ N+2) → rsp_valid high from cycle M+1.
- Illegal op accepted at N → rsp_valid high at N+1.
- Timeout: rsp_err=1 with rsp_valid high exactly TIMEOUT_CYCLES+2 cycles after accept.
- After the response is consumed at edge R, req_ready is high at R+1. There is no same-cycle turnaround.
- Reset asserted mid-operation: all outputs return to their reset values in the same cycle. The in-flight command is dropped with no response.

## Configuration
- ALU_CMD_STATS_EN defined:
  - stat_done increments on each accepted response with err=0.
  - stat_err increments on each accepted response with err=1.
  - Both are 16-bit and saturate at 0xFFFF.
- ALU_CMD_STATS_EN undefined: stat_done and stat_err are constant 0, with no counter logic.

## Structure
- Shared package alu16_pkg holds:
  - opcode localparams (OP_ADD…OP_TST, OP_ILLEGAL=4'b1111);
  - FSM state encoding;
  - the default TIMEOUT_CYCLES.
- One natural sub-module: alu_cmd_timeout, a clearable up-counter with a terminal-count flag, instantiated once.

## Test plan
- ADD with a=0x0003, b=0x0004 and a model control unit finishing 3 cycles after start, dp_result=0x0007 → rsp_result=0x0007, rsp_err=0, rsp_op=0000, cu_start high exactly one cycle.
- MUL op 0010 with rsp_ready held low 5 cycles after rsp_valid → response fields stable, req_ready=0 throughout, IDLE one cycle after rsp_ready.
- req_op=1111 → rsp_valid at accept+1 with rsp_err=1 and rsp_result=0; cu_start never asserted.
- TIMEOUT_CYCLES=8 with cu_finish never asserted → rsp_err=1 and rsp_valid at accept+10; a late cu_finish during RESP is ignored.
- rst pulsed during WAIT of a DIV (0011) → outputs reset immediately, no response; a following ADD completes normally.
- With ALU_CMD_STATS_EN, 3 good operations plus 1 illegal → stat_done=3, stat_err=1; without the macro both stay 0.
